// File: rtl/irq_enc_pkg.sv
// Shared types and constants for the 4-to-2 request encoder.
// Imported by the picker and the top-level encoder.
package irq_enc_pkg;

    localparam int N_REQ         = 4;
    localparam int IDX_W         = 2;
    localparam int RR_MODE_FIXED = 0;
    localparam int RR_MODE_RR    = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

endpackage

// File: rtl/irq_enc_4x2_pick.sv
// Combinational picker: fixed priority (highest bit) or
// round-robin starting one past the last grant.
module enc_pick
    import irq_enc_pkg::*;
(
    input  logic [N_REQ-1:0] pend,
    input  logic [IDX_W-1:0] last,
    input  logic             mode,
    output logic [IDX_W-1:0] idx,
    output logic             any_set
);

    logic [IDX_W-1:0] j;

    always_comb begin
        idx     = '0;
        j       = '0;
        any_set = |pend;
        if (mode) begin
            // Scan far-to-near so the nearest bit after last wins.
            for (int k = N_REQ; k >= 1; k--) begin
                j = last + IDX_W'(k);
                if (pend[j]) idx = j;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (pend[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_enc_4x2.sv
// Sequential 4-to-2 request encoder with pending latch,
// valid/ready offer and lost-request pulse.
module irq_enc_4x2
    import irq_enc_pkg::*;
#(
    parameter int RR_MODE = RR_MODE_FIXED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_in,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready,
    output logic [N_REQ-1:0] pending,
    output logic             lost
);

    localparam logic MODE = (RR_MODE == RR_MODE_RR);

    state_t           state, state_nx;
    logic             valid_nx;
    logic [IDX_W-1:0] idx_nx;
    logic [IDX_W-1:0] last, last_nx;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] pend_nx;
    logic             lost_nx;
    logic             hs;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    enc_pick u_pick (
        .pend    (pending),
        .last    (last),
        .mode    (MODE),
        .idx     (pick_idx),
        .any_set (pick_any)
    );

    assign hs = out_valid & out_ready;

    always_comb begin
        clr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            clr[i] = hs && (out_idx == IDX_W'(i));
        end
    end

    // Set wins over clear on the same bit.
    assign pend_nx = req_in | (pending & ~clr);
    assign lost_nx = |(req_in & pending & ~clr);

    always_comb begin
        state_nx = state;
        valid_nx = out_valid;
        idx_nx   = out_idx;
        last_nx  = last;
        unique case (state)
            IDLE: begin
                valid_nx = 1'b0;
                if (pick_any) begin
                    idx_nx   = pick_idx;
                    valid_nx = 1'b1;
                    state_nx = OFFER;
                end
            end
            OFFER: begin
                if (out_ready) begin
                    valid_nx = 1'b0;
                    last_nx  = out_idx;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_idx   <= '0;
            last      <= IDX_W'(N_REQ - 1);
            pending   <= '0;
            lost      <= 1'b0;
        end else begin
            state     <= state_nx;
            out_valid <= valid_nx;
            out_idx   <= idx_nx;
            last      <= last_nx;
            pending   <= pend_nx;
            lost      <= lost_nx;
        end
    end

endmodule

// File: doc/irq_enc_4x2.md
Name: irq_enc_4x2

Overview:
- Sequential 4-to-2 request encoder; the inverse of the 2-to-4 one-hot decoder.
- Latches up to N_REQ request lines into a pending register and selects one pending request per priority mode.
- Offers the selected binary index to a consumer over a valid/ready handshake, then clears the served request.
- Sits in front of the control unit / interrupt path, which consumes the 2-bit index.

Parameters:
- N_REQ, 4, number of request lines (fixed at 4 for this block; kept for readability).
- IDX_W, 2, index width, equal to clog2(N_REQ).
- RR_MODE, 0, 0 = fixed priority (highest bit wins), 1 = round-robin starting after the last grant.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_in  input  N_REQ  request lines, sampled every clk edge; high = set pending.
- out_valid  output  1  index offer is valid.
- out_idx  output  IDX_W  binary index of the offered request.
- out_ready  input  1  consumer accepts the offer (handshake = out_valid & out_ready at an edge).
- pending  output  N_REQ  current pending register (debug/status).
- lost  output  1  one-cycle pulse: a req_in bit was asserted while that bit was already pending and not being cleared.

Behaviour:
- Reset (rst=1 at an edge): pending=0, out_valid=0, out_idx=0, lost=0, state=IDLE, rr pointer last=N_REQ-1 (so the first round-robin search starts at bit 0). Reset overrides all other activity, including a handshake in progress.
- Pending update, each edge: pending_next[i] = req_in[i] | (pending[i] & ~clr[i]).
  - clr[i] = handshake this edge and out_idx==i.
  - Set wins over clear on the same bit.
- lost (registered): next = OR over i of (req_in[i] & pending[i] & ~clr[i]).
- FSM states: IDLE, OFFER.
  - IDLE: if pending (registered value, excluding requests arriving this cycle) != 0, then at the edge load out_idx with the selected index, set out_valid=1, go to OFFER. Otherwise stay, out_valid=0.
  - OFFER: out_idx and out_valid are held stable until the handshake.
    - On a handshake edge: clear pending[out_idx] per the rule above, out_valid=0, update last=out_idx, go to IDLE.
    - Without out_ready, remain in OFFER indefinitely. Newly arriving requests only accumulate in pending and never change out_idx mid-offer.
- Selection:
  - RR_MODE=0: highest set pending bit (bit 3 > 2 > 1 > 0).
  - RR_MODE=1: first set bit scanning (last+1) mod N_REQ upward with wrap-around (3 wraps to 0).
- Latency: req_in[i] high at edge k sets pending at k. If the FSM is in IDLE during cycle k..k+1, out_valid rises at edge k+1.
- Throughput: at most one grant per 2 cycles, because IDLE is mandatory between offers.
- Index arithmetic is unsigned IDX_W-bit; wrap is modulo N_REQ.
- A handshake on a bit whose req_in is simultaneously high leaves that bit pending, and it is re-offered after IDLE.
- out_ready while out_valid=0 is ignored.
- Reset mid-OFFER drops the offer with no clear side effect beyond pending=0.

Decomposition:
- Shared package irq_enc_pkg:
  - state enum {IDLE, OFFER}
  - constants N_REQ=4, IDX_W=2, RR_MODE_FIXED=0, RR_MODE_RR=1
- Sub-module enc_pick: combinational picker taking pending, last and mode, returning index and any_set.
- Top level holds the registers, FSM and lost logic.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with req_in=4'b1111 → out_valid=0, pending=0, lost=0. After release, pending=4'b1111 next edge and out_valid=1 one edge later.
- Fixed priority, RR_MODE=0:
  - Stimulus: pulse req_in=4'b0101 for one cycle, out_ready=1 constantly.
  - Required offers: out_idx=2 first, then out_idx=0, with one IDLE cycle between. pending ends at 0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after an offer of idx 1, and pulse req_in[3] meanwhile.
  - Required: out_idx stays 1 and out_valid stays 1 throughout. After out_ready=1, the next offer is idx 3.
- Round-robin wrap, RR_MODE=1:
  - Stimulus: hold req_in=4'b1001 continuously, out_ready=1.
  - Required grant sequence: 0, 3, 0, 3, … (pointer wraps 3→0).
- Set-wins and lost:
  - Stimulus: req_in[2] high on the handshake edge for idx 2 → pending[2] remains 1 and idx 2 is offered again.
  - Stimulus: req_in[2] re-asserted while pending[2]=1 with no clear → lost=1 for exactly one cycle.
- Reset mid-OFFER: assert rst while out_valid=1 → next edge out_valid=0 and pending=0. After release, the first RR grant scans from bit 0.
